// File: rtl/fetch_pkg.sv
// Shared fetch-side types: parcel bundle, aligner FSM states and constants.
// Imported by the aligner top and its parcel queue.
package fetch_pkg;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam int PARCELS_PER_WORD = 4;

  typedef struct packed {
    logic [15:0] data;
    logic [63:0] addr;
    logic [4:0]  cause;
  } parcel_t;

  typedef enum logic {
    RUN,
    HALT
  } state_e;

endpackage

// File: rtl/parcel_fifo.sv
// Circular queue of 16-bit parcels: up to four pushed and two popped per cycle.
// Exposes occupancy and the two oldest entries.
module parcel_fifo
  import fetch_pkg::*;
#(
  parameter int PARCELS = 8,
  localparam int PW = $clog2(PARCELS)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic [2:0] push_n,
  input  parcel_t [PARCELS_PER_WORD-1:0] push_data,
  input  logic [1:0] pop_n,
  output logic [PW:0] count,
  output parcel_t head0,
  output parcel_t head1
);

  parcel_t mem [PARCELS];
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  logic [PW-1:0] rd_nxt;

  assign count  = wr_ptr - rd_ptr;
  assign rd_nxt = rd_ptr[PW-1:0] + 1'b1;
  assign head0  = mem[rd_ptr[PW-1:0]];
  assign head1  = mem[rd_nxt];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + {{(PW-2){1'b0}}, push_n};
      rd_ptr <= rd_ptr + {{(PW-1){1'b0}}, pop_n};
    end
  end

  // Storage needs no reset; only slots below wr_ptr are ever read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < PARCELS_PER_WORD; i++) begin
      if (!clr && (3'(i) < push_n))
        mem[wr_ptr[PW-1:0] + PW'(i)] <= push_data[i];
    end
  end

endmodule

// File: rtl/inst_align.sv
// Instruction aligner: splits fetch words into parcels and issues one
// aligned 16/32-bit instruction per cycle to decode.
module inst_align
  import fetch_pkg::*;
#(
  parameter int PARCELS = 8,
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [63:0] flush_pc,
  input  logic        stall,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [63:0] fetch_addr,
  input  logic [63:0] fetch_data,
  input  logic [4:0]  fetch_cause,
  output logic [63:0] next_fetch_addr,
  output logic        valid_out,
  output logic [63:0] pc_out,
  output logic [31:0] inst_out,
  output logic [4:0]  cause_out,
  output logic [63:0] tval_out
);

  localparam int PW = $clog2(PARCELS);
  localparam int CW = PW + 1;

  state_e state_q, state_d;
  logic [63:0] nfa_q;
  logic [1:0]  drop_q;
  logic [PW:0] count, free;
  parcel_t head0, head1;
  parcel_t [PARCELS_PER_WORD-1:0] push_data;
  logic [2:0] push_n;
  logic [1:0] pop_n;
  logic take, is32, has1, has2, f0, f1;
  logic issue, fault;
  logic unused_ok;

  assign unused_ok = flush_pc[0];
  assign next_fetch_addr = nfa_q;

  assign free = CW'(PARCELS) - count;
  assign fetch_ready = (free >= CW'(4)) & !flush & (state_q == RUN);
  assign take = fetch_valid & fetch_ready & (fetch_addr == nfa_q);
  assign push_n = take ? (3'd4 - {1'b0, drop_q}) : 3'd0;

  always_comb begin
    for (int i = 0; i < PARCELS_PER_WORD; i++) begin
      push_data[i].data  = fetch_data[{drop_q + 2'(i), 4'b0} +: 16];
      push_data[i].addr  = {fetch_addr[63:3], drop_q + 2'(i), 1'b0};
      push_data[i].cause = fetch_cause;
    end
  end

  parcel_fifo #(.PARCELS(PARCELS)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (flush),
    .push_n    (push_n),
    .push_data (push_data),
    .pop_n     (pop_n),
    .count     (count),
    .head0     (head0),
    .head1     (head1)
  );

  assign is32 = (head0.data[1:0] == 2'b11);
  assign has1 = (count != '0);
  assign has2 = (count >= CW'(2));
  assign f0 = has1 & (head0.cause != '0);
  assign f1 = is32 & has2 & (head1.cause != '0);
  assign fault = f0 | f1;
  // A faulted head issues even when its 32-bit partner never arrives.
  assign issue = !stall & !flush & (state_q == RUN)
               & has1 & (!is32 | has2 | f0);
  assign pop_n = !issue ? 2'd0 : ((is32 & has2) ? 2'd2 : 2'd1);

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      flush:           state_d = RUN;
      (issue & fault): state_d = HALT;
      default:         state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      nfa_q   <= RESET_PC & ~64'h7;
      drop_q  <= RESET_PC[2:1];
    end else begin
      state_q <= state_d;
      if (flush) begin
        nfa_q  <= flush_pc & ~64'h7;
        drop_q <= flush_pc[2:1];
      end else if (take) begin
        nfa_q  <= nfa_q + 64'd8;
        drop_q <= 2'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      pc_out    <= '0;
      inst_out  <= INST_NOP;
      cause_out <= '0;
      tval_out  <= '0;
    end else if (flush) begin
      valid_out <= 1'b0;
      pc_out    <= '0;
      inst_out  <= INST_NOP;
      cause_out <= '0;
      tval_out  <= '0;
    end else if (!stall && state_q == RUN) begin
      if (issue) begin
        valid_out <= 1'b1;
        pc_out    <= head0.addr;
        if (fault) begin
          inst_out  <= INST_NOP;
          cause_out <= f0 ? head0.cause : head1.cause;
          tval_out  <= f0 ? head0.addr : head1.addr;
        end else begin
          inst_out  <= is32 ? {head1.data, head0.data}
                            : {16'h0, head0.data};
          cause_out <= '0;
          tval_out  <= '0;
        end
      end else begin
        valid_out <= 1'b0;
        inst_out  <= INST_NOP;
      end
    end
  end

endmodule

// File: tb/tb_inst_align.sv
// Scoreboard bench for inst_align: parcel-stream reference model feeds an
// expected queue that a negedge monitor drains against the DUT outputs.
module tb_inst_align;
  import fetch_pkg::*;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic clk, rst_n, flush, stall, fetch_valid, fetch_ready;
  logic [63:0] flush_pc, fetch_addr, fetch_data, next_fetch_addr;
  logic [4:0] fetch_cause, cause_out;
  logic valid_out;
  logic [63:0] pc_out, tval_out;
  logic [31:0] inst_out;

  inst_align #(.PARCELS(8), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .flush_pc(flush_pc),
    .stall(stall), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_addr(fetch_addr), .fetch_data(fetch_data),
    .fetch_cause(fetch_cause), .next_fetch_addr(next_fetch_addr),
    .valid_out(valid_out), .pc_out(pc_out), .inst_out(inst_out),
    .cause_out(cause_out), .tval_out(tval_out)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [4:0]  cause;
    logic [63:0] tval;
  } exp_t;
  typedef struct {
    logic [15:0] d;
    logic [63:0] a;
    logic [4:0]  c;
  } mpar_t;

  exp_t  exp_q[$];
  mpar_t par_q[$];
  int checks = 0, errors = 0;
  logic [63:0] m_nfa;
  int  m_drop;
  bit  m_halt, seen_fault, stall_rand;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: consume the in-order parcel stream into whole instructions.
  task automatic decode();
    mpar_t h;
    while (!m_halt && par_q.size() > 0) begin
      h = par_q[0];
      if (h.c != 0) begin
        exp_q.push_back('{h.a, INST_NOP, h.c, h.a});
        m_halt = 1;
      end else if (h.d[1:0] != 2'b11) begin
        exp_q.push_back('{h.a, {16'h0, h.d}, 5'd0, 64'd0});
        par_q.delete(0);
      end else if (par_q.size() < 2) begin
        break;
      end else if (par_q[1].c != 0) begin
        exp_q.push_back('{h.a, INST_NOP, par_q[1].c, h.a + 64'd2});
        m_halt = 1;
      end else begin
        exp_q.push_back('{h.a, {par_q[1].d, h.d}, 5'd0, 64'd0});
        par_q.delete(0);
        par_q.delete(0);
      end
    end
    if (m_halt) par_q.delete();
  endtask

  // Model update for the coming edge, after the monitor has sampled.
  always @(negedge clk) begin
    logic [63:0] rp;
    #1;
    rp = RST_PC;
    if (!rst_n) begin
      m_nfa = rp & ~64'h7;
      m_drop = int'(rp[2:1]);
      par_q.delete(); exp_q.delete();
      m_halt = 0; seen_fault = 0;
    end else if (flush) begin
      m_nfa = flush_pc & ~64'h7;
      m_drop = int'(flush_pc[2:1]);
      par_q.delete(); exp_q.delete();
      m_halt = 0; seen_fault = 0;
    end else if (fetch_valid && fetch_ready && fetch_addr == m_nfa) begin
      if (!m_halt)
        for (int i = m_drop; i < 4; i++)
          par_q.push_back('{fetch_data[16*i +: 16],
                            m_nfa + 64'(2 * i), fetch_cause});
      m_drop = 0;
      m_nfa = m_nfa + 64'd8;
      decode();
    end
  end

  logic prev_stall, prev_flush;
  logic [63:0] s_pc;
  logic [37:0] s_misc;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 0;
      prev_flush = 1;
    end else begin
      if (prev_stall && !prev_flush) begin
        chk("stall_hold_pc", pc_out, s_pc);
        chk("stall_hold_misc", 64'({valid_out, cause_out, inst_out}),
            64'(s_misc));
      end else if (!prev_flush && valid_out && !seen_fault) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_issue pc=%h inst=%h required=none",
                   pc_out, inst_out);
        end else begin
          e = exp_q.pop_front();
          chk("pc", pc_out, e.pc);
          chk("inst", 64'(inst_out), 64'(e.inst));
          chk("cause", 64'(cause_out), 64'(e.cause));
          chk("tval", tval_out, e.tval);
        end
        if (cause_out != 0) seen_fault = 1;
      end
      if (seen_fault) chk("halt_ready", 64'(fetch_ready), 64'd0);
      chk("next_fetch_addr", next_fetch_addr, m_nfa);
      prev_stall = stall;
      prev_flush = flush;
    end
    s_pc = pc_out;
    s_misc = {valid_out, cause_out, inst_out};
  end

  initial begin
    stall_rand = 0;
    forever begin
      @(posedge clk); #1;
      if (stall_rand) stall = ($urandom_range(0, 3) == 0);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] d,
                      input logic [4:0] c);
    bit ok = 0;
    fetch_valid = 1; fetch_addr = a; fetch_data = d; fetch_cause = c;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = fetch_ready;
      tick();
    end
    fetch_valid = 0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout addr=%h ready=0 required=1", a);
    end
  endtask

  task automatic do_flush(input logic [63:0] pc);
    flush = 1; flush_pc = pc;
    tick();
    flush = 0;
  endtask

  task automatic run_prog(input logic [63:0] start, input int nwords,
                          input bit fault_last);
    logic [15:0] img[$];
    logic [15:0] p, q;
    logic [63:0] base, d;
    logic [4:0] c;
    do_flush(start);
    base = start & ~64'h7;
    for (int i = 0; i < int'(start[2:1]); i++) img.push_back(16'hffff);
    while (img.size() < nwords * 4) begin
      p = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        q = 16'($urandom);
        p[1:0] = 2'b11;
        img.push_back(p); img.push_back(q);
      end else begin
        if (p[1:0] == 2'b11) p[1:0] = 2'b01;
        img.push_back(p);
      end
    end
    for (int w = 0; w < nwords; w++) begin
      d = {img[4*w+3], img[4*w+2], img[4*w+1], img[4*w]};
      c = (fault_last && w == nwords - 1) ? 5'($urandom_range(1, 31)) : 5'd0;
      if ($urandom_range(0, 7) == 0)
        send(base + 64'(8 * w) + 64'h40, 64'($urandom), 5'd0);
      send(base + 64'(8 * w), d, c);
    end
    repeat (40) tick();
    chk("drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst_n = 0; flush = 0; flush_pc = 0; stall = 0;
    fetch_valid = 0; fetch_addr = 0; fetch_data = 0; fetch_cause = 0;
    repeat (3) tick();
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_pc", pc_out, 64'd0);
    chk("rst_inst", 64'(inst_out), 64'h13);
    chk("rst_cause", 64'(cause_out), 64'd0);
    chk("rst_tval", tval_out, 64'd0);
    chk("rst_nfa", next_fetch_addr, 64'h8000_0000);
    rst_n = 1;
    tick();

    // Basic word, two-edge latency
    fetch_valid = 1; fetch_addr = 64'h8000_0000;
    fetch_data = 64'h00a00093_4501_0505; fetch_cause = 0;
    @(negedge clk);
    chk("ready_idle", 64'(fetch_ready), 64'd1);
    tick();
    fetch_valid = 0;
    @(negedge clk);
    chk("lat_e0_valid", 64'(valid_out), 64'd0);
    @(negedge clk);
    chk("lat_e1_valid", 64'(valid_out), 64'd1);
    chk("lat_e1_pc", pc_out, 64'h8000_0000);
    repeat (4) tick();

    // Straddling 32-bit instruction
    send(64'h8000_0008, 64'h0093_0001_0001_0001, 0);
    repeat (6) tick();
    @(negedge clk);
    chk("straddle_wait", 64'(valid_out), 64'd0);
    send(64'h8000_0010, 64'h0001_0001_0001_00a0, 0);
    repeat (8) tick();

    // Full queue under stall, then flush with a word on the bus
    stall = 1;
    send(64'h8000_0018, 64'h4511_450d_4509_4505, 0);
    send(64'h8000_0020, 64'h4521_451d_4519_4515, 0);
    fetch_valid = 1; fetch_addr = 64'h8000_0028; fetch_data = 64'h4525;
    @(negedge clk);
    chk("full_ready", 64'(fetch_ready), 64'd0);
    tick();
    flush = 1; flush_pc = 64'h8000_0106;
    @(negedge clk);
    chk("flush_ready", 64'(fetch_ready), 64'd0);
    tick();
    flush = 0; fetch_valid = 0; stall = 0;
    @(negedge clk);
    chk("flush_nfa", next_fetch_addr, 64'h8000_0100);
    chk("flush_valid", 64'(valid_out), 64'd0);
    chk("flush_inst", 64'(inst_out), 64'h13);
    tick();
    send(64'h8000_0040, 64'h1111_2222_3333_4444, 0);
    @(negedge clk);
    chk("stale_nfa", next_fetch_addr, 64'h8000_0100);
    tick();
    send(64'h8000_0100, 64'h0001_4501_beef_dead, 0);
    for (int t = 0; t < 10 && !valid_out; t++) @(negedge clk);
    chk("flush_first_pc", pc_out, 64'h8000_0106);
    repeat (4) tick();

    // Fault on the second half of a straddling instruction
    do_flush(64'h8000_0200);
    send(64'h8000_0200, 64'h0093_0001_0001_0001, 0);
    send(64'h8000_0208, 64'h0001_0001_0001_00a0, 5'd1);
    repeat (4) tick();
    fetch_valid = 1; fetch_addr = 64'h8000_0210; fetch_data = 0;
    repeat (5) tick();
    @(negedge clk);
    chk("fault_ready", 64'(fetch_ready), 64'd0);
    chk("fault_valid", 64'(valid_out), 64'd1);
    chk("fault_cause", 64'(cause_out), 64'd1);
    chk("fault_pc", pc_out, 64'h8000_0206);
    chk("fault_tval", tval_out, 64'h8000_0208);
    chk("fault_inst", 64'(inst_out), 64'h13);
    tick();
    fetch_valid = 0;

    // Stall while the queue fills
    do_flush(64'h8000_0300);
    stall = 1;
    send(64'h8000_0300, 64'h00a00093_4501_0505, 0);
    send(64'h8000_0308, 64'h0011_0093_4509_0001, 0);
    fetch_valid = 1; fetch_addr = 64'h8000_0310;
    fetch_data = 64'h4505_4505_4505_4505;
    repeat (3) begin
      @(negedge clk);
      chk("stall_full_ready", 64'(fetch_ready), 64'd0);
      tick();
    end
    stall = 0;
    send(64'h8000_0310, 64'h4505_4505_4505_4505, 0);
    repeat (12) tick();
    chk("stall_drained", 64'(exp_q.size()), 64'd0);

    // Randomised programs with random stalls, stale words and faults
    stall_rand = 1;
    for (int k = 0; k < 25; k++)
      run_prog(64'h8000_0000 + 64'($urandom_range(0, 4095) * 2),
               $urandom_range(1, 12), $urandom_range(0, 4) == 0);
    run_prog(64'hFFFF_FFFF_FFFF_FFFA, 2, 0);
    stall_rand = 0;
    tick();
    stall = 0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_align.md
Name: inst_align

Overview:
- Fetch-side producer for the decode stage's `pc_in`/`inst_in`/`cause_in`/`tval_in` interface.
- Takes 64-bit, 8-byte-aligned fetch words from the I-cache and splits them into 16-bit parcels.
- Reassembles 16-bit (compressed) and 32-bit instructions, including 32-bit instructions that straddle two fetch words.
- Presents one aligned instruction per cycle with its PC and any fetch fault; supports pipeline stall and branch/trap redirect.

Parameters:
- PARCELS, 8, parcel queue depth in 16-bit parcels; power of 2, minimum 8.
- RESET_PC, 64'h0000_0000_8000_0000, PC after reset; bit 0 must be 0.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  redirect (bj_en | trap_en from later stages)
- flush_pc  in  64  redirect target; bit 0 is 0
- stall  in  1  decode stage holding; output register must not change
- fetch_valid  in  1  fetch word present
- fetch_ready  out  1  aligner accepts the word this cycle
- fetch_addr  in  64  address of the fetch word; bits [2:0] are 0
- fetch_data  in  64  four parcels; parcel 0 = bits [15:0]
- fetch_cause  in  5  0 = no fault, else the fetch exception cause
- next_fetch_addr  out  64  8-byte-aligned address of the next word the aligner expects
- valid_out  out  1  output instruction valid
- pc_out  out  64  instruction PC
- inst_out  out  32  instruction; a compressed instruction is zero-extended in [31:16]
- cause_out  out  5  fault cause, 0 if none
- tval_out  out  64  faulting address, 0 if none

Behaviour:
- Reset (asynchronous):
  - Queue is empty; `valid_out` = 0; `pc_out` = 0; `inst_out` = 32'h0000_0013; `cause_out` = 0; `tval_out` = 0.
  - `next_fetch_addr` = RESET_PC & ~7; drop offset = RESET_PC[2:1]; FSM = RUN.
- Accept: `fetch_ready` = (free parcels ≥ 4) & !flush & (state == RUN).
  - A handshake is `fetch_valid & fetch_ready`.
- Address check on a handshake:
  - If `fetch_addr` != `next_fetch_addr`, the word is stale and is discarded without error.
  - Otherwise push parcels [drop_offset..3] into the queue, each tagged with its address and `fetch_cause`.
  - Then clear drop_offset and advance `next_fetch_addr` by 8 (wraps modulo 2^64).
- Length: a head parcel with [1:0] != 2'b11 is 16-bit; otherwise the instruction is 32-bit and needs 2 parcels.
- Issue, evaluated each cycle with !stall & !flush & state == RUN:
  - Issue if the head instruction is complete (count ≥ 1 for 16-bit, count ≥ 2 for 32-bit).
  - Issue also if the head parcel is faulted, or if the head is 32-bit with count ≥ 2 and the second parcel is faulted.
  - On issue, load the output register and pop 1 or 2 parcels.
  - With no issue and !stall, `valid_out` goes to 0 and `inst_out` to NOP (32'h0000_0013).
- Latency: a word accepted at edge E0 produces its first instruction on the outputs after edge E1 (2 edges). At most one instruction per cycle. The queue keeps accepting words while stalled.
- Fault issue:
  - `inst_out` = NOP; `cause_out` = the fault's cause; `pc_out` = head PC.
  - `tval_out` = head PC if the head parcel faulted, else head PC+2 (second half of a straddling instruction faulted).
  - FSM goes RUN→HALT. In HALT nothing is accepted or issued; the registered fault instruction stays on the outputs until flush.
- Flush (priority over stall and handshake, all on the same edge):
  - Queue is cleared and any same-cycle fetch word is dropped.
  - `valid_out` = 0 and outputs return to their reset values.
  - `next_fetch_addr` = flush_pc & ~7; drop offset = flush_pc[2:1]; FSM = RUN.
- Queue: read/write pointers are log2(PARCELS)+1 bits so full and empty are distinguishable; pointers wrap modulo PARCELS. Push and pop may happen on the same edge.
- Stall: output register and `valid_out` hold exactly.

Decomposition:
- Shared package `fetch_pkg`:
  - Parcel struct: data[15:0], addr[63:0], cause[4:0].
  - `INST_NOP` = 32'h0000_0013.
  - `PARCELS_PER_WORD` = 4.
  - FSM enum {RUN, HALT}.
- Sub-module `parcel_fifo`: a 4-in / 2-out-pop circular queue exposing count and the head two entries.
- The top level holds address tracking, length detect, the FSM and the output register.

Test Plan:
- Reset with RESET_PC = 0x8000_0000; word @0x8000_0000 with data {32'h00a00093 at [63:32], 16'h4501 at [31:16], 16'h0505 at [15:0]} → 0x8000_0000 inst 0x0505, 0x8000_0002 inst 0x4501, 0x8000_0004 inst 0x00a00093, one per cycle, first `valid_out` 2 edges after the handshake.
- Straddle: word @0x...00 ends with the low half of 32-bit 0x00a00093 in parcel 3; word @0x...08 follows → inst 0x00a00093 with pc 0x...06, issued only after the second word is accepted.
- Flush to 0x8000_0106 while the queue is full and fetch_valid = 1 → that word is dropped; `next_fetch_addr` = 0x8000_0100; the next word @0x8000_0100 yields its first instruction at pc 0x8000_0106; a stale word @0x8000_0040 is discarded.
- Fault: second word of a straddling instruction has fetch_cause = 1 → cause_out 1, pc_out 0x...06, tval_out 0x...08, inst_out NOP; `fetch_ready` stays 0 until flush.
- Stall held 5 cycles with the queue filling to PARCELS → outputs stable; `fetch_ready` drops at free < 4; after release the instructions drain in order with no loss or duplication.
